// File: rtl/tbl_lookup_rd_pkg.sv
// ----------------------------------------------------------------------------
// tbl_lookup_rd_pkg
// Purpose : Shared definitions for the match/action table read side. The
//           write/config side uses the same entry layout, so both sides agree
//           on where the entry-valid flag lives.
// Contents: entry_valid_bit() - bit position of the entry-valid flag
//           cnt_bits()        - width of an occupancy counter that can hold
//                               the value DEPTH itself
// ----------------------------------------------------------------------------
package tbl_lookup_rd_pkg;

    // The entry-valid flag is the most significant bit of a table entry.
    function automatic int entry_valid_bit(input int data_bits);
        return data_bits - 1;
    endfunction

    // One extra bit over the pointer width so "full" (count == depth) is
    // distinguishable from "empty" without relying on pointer comparison.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tbl_lookup_rd_res_fifo.sv
// ----------------------------------------------------------------------------
// lookup_res_fifo
// Purpose : Small synchronous result FIFO for the lookup read stage. The head
//           entry is read straight out of the storage registers, so the data
//           presented downstream is stable for as long as it is not popped.
// Ports   : clk      - clock
//           rst      - synchronous active-high reset, clears storage too
//           wr_en    - push wr_data this cycle
//           wr_data  - entry to push
//           rd_en    - pop the head entry this cycle
//           rd_data  - current head entry
//           count    - number of valid entries (0..DEPTH)
// ----------------------------------------------------------------------------
module lookup_res_fifo #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;

    // The head is just the storage register selected by the read pointer.
    // Because DEPTH is a power of two the pointers wrap naturally.
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and occupancy. Storage is cleared on reset so the
    // downstream data/tag outputs read as zero out of reset. A simultaneous
    // push and pop leaves the count alone while both pointers advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The upstream credit scheme guarantees a push never meets a full
    // buffer and a pop never meets an empty one.
    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && (count == FULL_COUNT)));

    underflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(rd_en && (count == '0)));

endmodule

// File: rtl/tbl_lookup_rd.sv
// ----------------------------------------------------------------------------
// tbl_lookup_rd
// Purpose : Read-side lookup stage for the match/action table RAM (port B of
//           the dual-port block RAM). Accepts table lookups over valid/ready,
//           issues the RAM read, captures the entry one cycle later together
//           with the request tag, and buffers results in a small FIFO so the
//           downstream consumer may apply full backpressure. One lookup per
//           clock is sustained while out_ready stays high.
// Ports   : clk, rst              - clock, synchronous active-high reset
//           in_valid/in_ready     - request handshake
//           in_addr, in_tag       - table index and opaque metadata
//           ram_addrb, ram_enb    - RAM port B address and read enable
//           ram_doutb             - RAM port B data, valid the cycle after enb
//           out_valid/out_ready   - result handshake
//           out_data, out_tag     - entry read and the originating tag
//           out_hit               - entry-valid flag of out_data
// ----------------------------------------------------------------------------
module tbl_lookup_rd #(
    parameter int ADDR_BITS  = 5,
    parameter int DATA_BITS  = 38,
    parameter int TAG_BITS   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic [TAG_BITS-1:0]  in_tag,
    output logic [ADDR_BITS-1:0] ram_addrb,
    output logic                 ram_enb,
    input  logic [DATA_BITS-1:0] ram_doutb,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic [TAG_BITS-1:0]  out_tag,
    output logic                 out_hit
);

    import tbl_lookup_rd_pkg::*;

    localparam int CNT_BITS = cnt_bits(FIFO_DEPTH);
    localparam int SUM_BITS = CNT_BITS + 1;
    localparam int HIT_BIT  = entry_valid_bit(DATA_BITS);
    localparam int RES_BITS = DATA_BITS + TAG_BITS;
    localparam logic [SUM_BITS-1:0] CREDIT_LIMIT = SUM_BITS'(FIFO_DEPTH);

    logic                accept;
    logic                inflight;
    logic                pop;
    logic [TAG_BITS-1:0] tag_d;
    logic [CNT_BITS-1:0] count;
    logic [SUM_BITS-1:0] credit_used;
    logic [RES_BITS-1:0] head;

    // Credit: every buffered result plus the read still in the RAM pipe
    // holds a FIFO slot. Only registered state feeds this, so out_ready has
    // no combinational path to in_ready, and a capture always finds room.
    assign credit_used = {1'b0, count} + {{CNT_BITS{1'b0}}, inflight};
    assign in_ready    = !rst && (credit_used < CREDIT_LIMIT);
    assign accept      = in_valid && in_ready;

    // The RAM read is issued in the same cycle the request is accepted.
    assign ram_addrb = in_addr;
    assign ram_enb   = accept;

    // Track the one outstanding RAM read and hold its tag until the data
    // comes back. Reset throws away any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            tag_d    <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                tag_d <= in_tag;
            end
        end
    end

    lookup_res_fifo #(
        .WIDTH (RES_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight),
        .wr_data ({ram_doutb, tag_d}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count)
    );

    // Results leave in request order straight from the FIFO head.
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = head[RES_BITS-1 -: DATA_BITS];
    assign out_tag   = head[TAG_BITS-1:0];
    assign out_hit   = out_data[HIT_BIT];

endmodule

// File: tb/tb_tbl_lookup_rd.sv
// ----------------------------------------------------------------------------
// tb_tbl_lookup_rd
// Purpose : Self-checking bench for tbl_lookup_rd. A behavioural dual-port
//           RAM on the same clock is preloaded through port A; the stage reads
//           it through port B. A queue of expected results (pushed on each
//           accepted request) predicts in_ready, out_valid and the result
//           stream every cycle, and directed sequences cover latency,
//           streaming, backpressure and reset in the middle of traffic.
// ----------------------------------------------------------------------------
module tb_tbl_lookup_rd;

    localparam int AW    = 5;
    localparam int DW    = 38;
    localparam int TW    = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [TW-1:0] in_tag;
    logic [AW-1:0] ram_addrb;
    logic          ram_enb;
    logic [DW-1:0] ram_doutb;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic          out_hit;

    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic [DW-1:0] ram_mem [32];

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
        logic [DW-1:0] exp_data;
        logic          exp_hit;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[4];

    int   n_cmp;
    int   n_fail;
    int   accept_cnt;
    int   enb_cnt;
    logic inflight_m;
    logic dut_pop;
    logic acc_s;
    logic rdy_s;

    tbl_lookup_rd #(
        .ADDR_BITS  (AW),
        .DATA_BITS  (DW),
        .TAG_BITS   (TW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_tag    (in_tag),
        .ram_addrb (ram_addrb),
        .ram_enb   (ram_enb),
        .ram_doutb (ram_doutb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_hit   (out_hit)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Block RAM model: port A write for configuration, port B read with a
    // one-cycle registered output, both on the lookup clock.
    always @(posedge clk) begin
        if (wea) begin
            ram_mem[addra] <= dina;
        end
        if (ram_enb) begin
            ram_doutb <= ram_mem[ram_addrb];
        end
    end

    // Table contents the bench loads; entries 3 and 4 are the fixed
    // hit/miss pair, the rest carry a pattern with hit = index parity.
    function automatic logic [DW-1:0] ram_model(input logic [AW-1:0] idx);
        logic [DW-1:0] v;
        case (idx)
            5'd3:    v = 38'h20_0000_0ABC;
            5'd4:    v = 38'h00_0000_0123;
            default: v = {idx[0], 10'h155, 22'(idx * 22'h1357), idx};
        endcase
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // One clock of traffic. At the falling edge the outputs are compared
    // with the model, then the inputs for the next rising edge are driven.
    // The queue holds every accepted-but-not-delivered lookup, so its size
    // equals FIFO occupancy plus the read in flight.
    task automatic apply_stimulus(input logic vld, input logic [AW-1:0] addr,
                                  input logic [TW-1:0] tag, input logic ordy);
        exp_t e;
        logic exp_rdy;
        logic exp_ov;
        @(negedge clk);
        exp_rdy = (sb_q.size() < DEPTH);
        exp_ov  = ((sb_q.size() - int'(inflight_m)) > 0);
        check_output("out_valid", out_valid, exp_ov);
        dut_pop = out_valid && ordy;
        if (exp_ov) begin
            e = sb_q[0];
            check_output("sb_data", out_data, e.data);
            check_output("sb_tag", out_tag, e.tag);
            check_output("sb_hit", out_hit, e.data[DW-1]);
            if (ordy) begin
                void'(sb_q.pop_front());
            end
        end
        in_valid  = vld;
        in_addr   = addr;
        in_tag    = tag;
        out_ready = ordy;
        #1;
        rdy_s = in_ready;
        check_output("in_ready", in_ready, exp_rdy);
        check_output("enb_vs_accept", ram_enb, vld && exp_rdy);
        if (ram_enb) begin
            enb_cnt++;
        end
        acc_s = vld && exp_rdy;
        if (acc_s) begin
            accept_cnt++;
            e.data = ram_model(addr);
            e.tag  = tag;
            sb_q.push_back(e);
        end
        inflight_m = acc_s;
    endtask

    // Single isolated lookup: nothing at t+1, the result at t+2, popped
    // immediately so the stage is empty again one cycle later.
    task automatic run_vector(input vec_t v, input string name);
        apply_stimulus(1'b1, v.addr, v.tag, 1'b1);
        apply_stimulus(1'b0, '0, '0, 1'b1);
        check_output({name, "_t1_valid"}, out_valid, 1'b0);
        apply_stimulus(1'b0, '0, '0, 1'b1);
        check_output({name, "_t2_valid"}, out_valid, 1'b1);
        check_output({name, "_data"}, out_data, v.exp_data);
        check_output({name, "_tag"}, out_tag, v.tag);
        check_output({name, "_hit"}, out_hit, v.exp_hit);
        apply_stimulus(1'b0, '0, '0, 1'b1);
        check_output({name, "_drained"}, out_valid, 1'b0);
    endtask

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_pop;
        int npop;
        int nacc;
        int cyc;
        int acc0;

        vecs[0] = '{addr: 5'd3,  tag: 16'h00A5, exp_data: 38'h20_0000_0ABC, exp_hit: 1'b1};
        vecs[1] = '{addr: 5'd4,  tag: 16'h0042, exp_data: 38'h00_0000_0123, exp_hit: 1'b0};
        vecs[2] = '{addr: 5'd0,  tag: 16'hFFFF, exp_data: 38'h0A_A800_0000, exp_hit: 1'b0};
        vecs[3] = '{addr: 5'd31, tag: 16'h5A5A, exp_data: 38'h2A_A84A_F13F, exp_hit: 1'b1};

        n_cmp      = 0;
        n_fail     = 0;
        accept_cnt = 0;
        enb_cnt    = 0;
        inflight_m = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_addr    = 5'd3;
        in_tag     = 16'hFFFF;
        out_ready  = 1'b0;
        wea        = 1'b0;
        addra      = '0;
        dina       = '0;

        // Hold reset while the table is loaded through port A; the stage
        // must refuse requests and keep enb low even with in_valid high.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 3) begin
                check_output("rst_in_ready", in_ready, 1'b0);
                check_output("rst_out_valid", out_valid, 1'b0);
                check_output("rst_enb", ram_enb, 1'b0);
                check_output("rst_out_data", out_data, '0);
                check_output("rst_out_tag", out_tag, '0);
                check_output("rst_out_hit", out_hit, 1'b0);
            end
            wea   = 1'b1;
            addra = 5'(i);
            dina  = ram_model(5'(i));
        end
        @(negedge clk);
        wea      = 1'b0;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_output("post_rst_in_ready", in_ready, 1'b1);
        check_output("post_rst_out_valid", out_valid, 1'b0);

        $display("[TB] single lookups");
        for (int v = 0; v < 4; v++) begin
            run_vector(vecs[v], $sformatf("vec%0d", v));
        end

        $display("[TB] streaming 32 back-to-back");
        first_pop = -1;
        npop      = 0;
        for (int c = 0; c < 40; c++) begin
            apply_stimulus(c < 32, 5'(c), 16'(16'h1000 + c), 1'b1);
            if (c < 32) begin
                check_output("stream_in_ready", rdy_s, 1'b1);
            end
            if (dut_pop) begin
                if (first_pop < 0) begin
                    first_pop = c;
                end
                check_output("stream_contig", c - first_pop, npop);
                npop++;
            end
        end
        check_output("stream_count", npop, 32);

        $display("[TB] backpressure");
        nacc = 0;
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(1'b1, 5'(8 + k), 16'(16'h2000 + k), 1'b0);
            if (acc_s) begin
                nacc++;
            end
        end
        check_output("bp_accepts", nacc, DEPTH);
        check_output("bp_in_ready_low", in_ready, 1'b0);
        check_output("bp_hold_data", out_data, ram_model(5'd8));
        check_output("bp_hold_tag", out_tag, 16'h2000);
        npop = 0;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b0, '0, '0, 1'b1);
            if (dut_pop) begin
                npop++;
            end
        end
        check_output("bp_drain_count", npop, DEPTH);
        check_output("bp_drained", out_valid, 1'b0);

        $display("[TB] random traffic");
        cyc  = 0;
        acc0 = accept_cnt;
        while ((accept_cnt - acc0) < 10000 && cyc < 40000) begin
            apply_stimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                           16'($urandom), 1'($urandom_range(0, 1)));
            cyc++;
        end
        check_output("rand_budget", (accept_cnt - acc0) >= 10000, 1'b1);
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(1'b0, '0, '0, 1'b1);
        end
        check_output("rand_drained", out_valid, 1'b0);
        check_output("enb_count", enb_cnt, accept_cnt);

        $display("[TB] reset mid-operation");
        apply_stimulus(1'b1, 5'd3, 16'h0301, 1'b0);
        apply_stimulus(1'b1, 5'd4, 16'h0302, 1'b0);
        apply_stimulus(1'b1, 5'd5, 16'h0303, 1'b0);
        @(negedge clk);
        check_output("mid_pre_valid", out_valid, 1'b1);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        check_output("mid_rst_enb", ram_enb, 1'b0);
        check_output("mid_rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_output("mid_post_valid", out_valid, 1'b0);
        check_output("mid_post_in_ready", in_ready, 1'b1);
        sb_q.delete();
        inflight_m = 1'b0;
        run_vector('{addr: 5'd4, tag: 16'hBEEF, exp_data: 38'h00_0000_0123, exp_hit: 1'b0}, "mid_lookup");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
